// File: rtl/router_link_port_pkg.sv
// Shared router types: packet layout, link byte geometry and link FSM states.
package RouterPkg;

  localparam int unsigned PKT_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_B1,
    RX_B2,
    RX_B3
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_B0,
    TX_B1,
    TX_B2,
    TX_B3
  } tx_state_t;

endpackage

// File: rtl/router_link_port_if.sv
// Crossbar-side packet handshakes of one router port (inbound drain, outbound fill).
interface router_link_port_if;
  import RouterPkg::*;

  pkt_t rx_pkt;
  logic rx_valid;
  logic rx_ready;
  pkt_t tx_pkt;
  logic tx_valid;
  logic tx_ready;

  // Crossbar side
  modport master (
    input  rx_pkt, rx_valid, tx_ready,
    output rx_ready, tx_pkt, tx_valid
  );

  // Link port side
  modport slave (
    output rx_pkt, rx_valid, tx_ready,
    input  rx_ready, tx_pkt, tx_valid
  );
endinterface

// File: rtl/router_link_port_fifo.sv
// Show-ahead packet FIFO; a push while full is accepted only alongside a pop.
module pkt_fifo
  import RouterPkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  pkt_t                       din_i,
  input  logic                       pop_i,
  output pkt_t                       head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/router_link_port.sv
// Router endpoint of a node<->router byte-serial link: inbound deserializer
// into a packet FIFO, outbound staging register plus byte shifter.
module router_link_port
  import RouterPkg::*;
#(
  parameter int unsigned RX_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              put_in,
  input  logic [BYTE_W-1:0] payload_in,
  output logic              free_in,
  input  logic              free_out,
  output logic              put_out,
  output logic [BYTE_W-1:0] payload_out,
  output logic              link_err,
  router_link_port_if.slave xb
);

  localparam int unsigned CW = $clog2(RX_DEPTH + 1);

  // ---------------- inbound ----------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [23:0]   rx_buf_q, rx_buf_d;
  logic          link_err_q, link_err_d;
  logic          alive_q;
  logic          rx_push, rx_pop;
  pkt_t          rx_push_pkt;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_empty;

  // alive_q keeps free_in low while reset is held
  assign free_in     = alive_q && (rx_state_q == RX_IDLE) && (rx_count < CW'(RX_DEPTH));
  assign rx_push_pkt = pkt_t'({rx_buf_q, payload_in});
  assign rx_pop      = !rx_empty && xb.rx_ready;
  assign xb.rx_valid = !rx_empty;
  assign link_err    = link_err_q;

  pkt_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (rx_push),
    .din_i   (rx_push_pkt),
    .pop_i   (rx_pop),
    .head_o  (xb.rx_pkt),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Inbound state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_buf_q   <= '0;
      link_err_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_buf_q   <= rx_buf_d;
      link_err_q <= link_err_d;
      alive_q    <= 1'b1;
    end
  end

  // Inbound byte assembly and protocol checking
  always_comb begin
    rx_state_d = rx_state_q;
    rx_buf_d   = rx_buf_q;
    rx_push    = 1'b0;
    link_err_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (put_in) begin
          if (free_in) begin
            rx_buf_d   = {rx_buf_q[15:0], payload_in};
            rx_state_d = RX_B1;
          end else begin
            link_err_d = 1'b1;
          end
        end
      end
      RX_B1: begin
        if (put_in) begin
          rx_buf_d   = {rx_buf_q[15:0], payload_in};
          rx_state_d = RX_B2;
        end else begin
          rx_state_d = RX_IDLE;
          link_err_d = 1'b1;
        end
      end
      RX_B2: begin
        if (put_in) begin
          rx_buf_d   = {rx_buf_q[15:0], payload_in};
          rx_state_d = RX_B3;
        end else begin
          rx_state_d = RX_IDLE;
          link_err_d = 1'b1;
        end
      end
      RX_B3: begin
        rx_state_d = RX_IDLE;
        if (put_in) rx_push    = 1'b1;
        else        link_err_d = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- outbound ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [31:0] stg_q, stg_d;
  logic        stg_full_q, stg_full_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic        put_out_q, put_out_d;
  logic [7:0]  payload_out_q, payload_out_d;
  logic        tx_load, tx_accept;

  assign xb.tx_ready = !stg_full_q;
  assign tx_accept   = xb.tx_valid && !stg_full_q;
  assign tx_load     = stg_full_q && free_out &&
                       ((tx_state_q == TX_IDLE) || (tx_state_q == TX_B3));
  assign put_out     = put_out_q;
  assign payload_out = payload_out_q;

  // Outbound staging, shifter and registered link outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q    <= TX_IDLE;
      stg_q         <= '0;
      stg_full_q    <= 1'b0;
      tx_shift_q    <= '0;
      put_out_q     <= 1'b0;
      payload_out_q <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      stg_q         <= stg_d;
      stg_full_q    <= stg_full_d;
      tx_shift_q    <= tx_shift_d;
      put_out_q     <= put_out_d;
      payload_out_q <= payload_out_d;
    end
  end

  // Outbound sequencing; a load in TX_B3 overrides the return to idle
  always_comb begin
    stg_d         = stg_q;
    stg_full_d    = stg_full_q;
    tx_state_d    = tx_state_q;
    tx_shift_d    = tx_shift_q;
    put_out_d     = 1'b0;
    payload_out_d = '0;

    if (tx_load) stg_full_d = 1'b0;
    if (tx_accept) begin
      stg_d      = xb.tx_pkt;
      stg_full_d = 1'b1;
    end

    unique case (tx_state_q)
      TX_IDLE: tx_state_d = TX_IDLE;
      TX_B0, TX_B1, TX_B2: begin
        put_out_d     = 1'b1;
        payload_out_d = tx_shift_q[31:24];
        tx_shift_d    = {tx_shift_q[23:0], 8'h00};
        tx_state_d    = (tx_state_q == TX_B0) ? TX_B1 :
                        (tx_state_q == TX_B1) ? TX_B2 : TX_B3;
      end
      TX_B3:   tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_state_d    = TX_B0;
      put_out_d     = 1'b1;
      payload_out_d = stg_q[31:24];
      tx_shift_d    = {stg_q[23:0], 8'h00};
    end
  end

endmodule
